// File: rtl/id_stage_pipe_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU/load encodings, control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OP_AND   = 3'b011;
    localparam logic [2:0] ALU_OP_OR    = 3'b100;
    localparam logic [2:0] ALU_OP_SLT   = 3'b101;

    localparam logic [1:0] LOAD_WORD = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_BYTE = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] load_mode;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_FUNCT; end
            OP_LW, OP_LH, OP_LB: begin
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.alu_op     = ALU_OP_ADD;
                c.load_mode  = (op == OP_LW) ? LOAD_WORD : ((op == OP_LH) ? LOAD_HALF : LOAD_BYTE);
            end
            OP_SW:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = ALU_OP_ADD; end
            OP_BEQ:  begin c.branch = 1'b1; c.alu_op = ALU_OP_SUB; end
            OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_ADD; end
            OP_ANDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_AND; end
            OP_ORI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_OR; end
            OP_SLTI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_SLT; end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

    // Only these formats use rt as a source; for the rest it is the destination.
    function automatic logic reads_rt(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_SW, OP_BEQ: reads_rt = 1'b1;
            default:                 reads_rt = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// NUM_REGS x XLEN register file, two read ports, one write port,
// hard-wired zero register and same-cycle write-through bypass.
module id_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    localparam int RA_W    = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [RA_W-1:0] waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [RA_W-1:0] raddr_a_i,
    input  logic [RA_W-1:0] raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    // Storage; entry 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i == '0) rdata_a_o = '0;
        else if (we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
        else rdata_a_o = regs_q[raddr_a_i];
        if (raddr_b_i == '0) rdata_b_o = '0;
        else if (we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
        else rdata_b_o = regs_q[raddr_b_i];
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage with ID/EX register, load-use hazard stall and EX flush.
// Optional performance counters are enabled with `define ID_PERF_CNT_EN.
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int PC_W     = 32,
    localparam int RA_W    = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [PC_W-1:0] if_pc_plus4,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            stall,
    output logic            ex_valid,
    output logic [PC_W-1:0] ex_pc_plus4,
    output logic [XLEN-1:0] ex_rs_data,
    output logic [XLEN-1:0] ex_rt_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs,
    output logic [RA_W-1:0] ex_rt,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_dst,
    output logic            ex_reg_write,
    output logic            ex_alu_src,
    output logic            ex_mem_write,
    output logic            ex_mem_read,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic [1:0]      ex_load_mode,
    output logic [2:0]      ex_alu_op
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
`endif
);

    logic [5:0]      opcode_s;
    logic [RA_W-1:0] rs_s, rt_s, rd_s;
    logic [XLEN-1:0] rs_data_s, rt_data_s, imm_s;
    ctrl_t           dec_s, ctrl_d, ctrl_q;
    logic            valid_d, ex_valid_q, stall_s;
    logic [PC_W-1:0] pc_q;
    logic [XLEN-1:0] rs_data_q, rt_data_q, imm_q;
    logic [RA_W-1:0] rs_q, rt_q, rd_q;
    logic            unused_s;

    assign opcode_s = if_instr[31:26];
    assign rs_s     = if_instr[21 +: RA_W];
    assign rt_s     = if_instr[16 +: RA_W];
    assign rd_s     = if_instr[11 +: RA_W];
    assign imm_s    = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
    assign dec_s    = decode_op(opcode_s);
    assign unused_s = ^if_instr;

    id_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we_i      (wb_we),
        .waddr_i   (wb_waddr),
        .wdata_i   (wb_wdata),
        .raddr_a_i (rs_s),
        .raddr_b_i (rt_s),
        .rdata_a_o (rs_data_s),
        .rdata_b_o (rt_data_s)
    );

    // A load in EX whose destination feeds this instruction holds IF for one cycle.
    assign stall_s = if_valid & ex_valid_q & ctrl_q.mem_read & (rt_q != '0)
                   & ((rt_q == rs_s) | (reads_rt(opcode_s) & (rt_q == rt_s)))
                   & ~flush;
    assign stall   = stall_s;

    always_comb begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
        if (flush || stall_s || !if_valid) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else begin
            valid_d = 1'b1;
            ctrl_d  = dec_s;
        end
    end

    // ID/EX register; data fields load every cycle, bubbles only clear valid/control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            pc_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            ex_valid_q <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= if_pc_plus4;
            rs_data_q  <= rs_data_s;
            rt_data_q  <= rt_data_s;
            imm_q      <= imm_s;
            rs_q       <= rs_s;
            rt_q       <= rt_s;
            rd_q       <= rd_s;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc_plus4   = pc_q;
    assign ex_rs_data    = rs_data_q;
    assign ex_rt_data    = rt_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;
    assign ex_load_mode  = ctrl_q.load_mode;
    assign ex_alu_op     = ctrl_q.alu_op;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_s) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && if_valid) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed, table-driven bench for id_stage_pipe (default 32-bit build).
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        stall, ex_valid;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_reg_dst, ex_reg_write, ex_alu_src, ex_mem_write;
    logic        ex_mem_read, ex_mem_to_reg, ex_branch;
    logic [1:0]  ex_load_mode;
    logic [2:0]  ex_alu_op;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc_plus4(if_pc_plus4), .flush(flush), .wb_we(wb_we),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .stall(stall),
        .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_reg_dst(ex_reg_dst), .ex_reg_write(ex_reg_write),
        .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_load_mode(ex_load_mode), .ex_alu_op(ex_alu_op)
`ifdef ID_PERF_CNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    // {reg_dst,reg_write,alu_src,mem_write,mem_read,mem_to_reg,branch,load_mode,alu_op}
    localparam logic [11:0] C_NONE = 12'b0000000_00_000;
    localparam logic [11:0] C_R    = 12'b1100000_00_010;
    localparam logic [11:0] C_LW   = 12'b0110110_00_000;
    localparam logic [11:0] C_LH   = 12'b0110110_01_000;
    localparam logic [11:0] C_LB   = 12'b0110110_10_000;
    localparam logic [11:0] C_SW   = 12'b0011000_00_000;
    localparam logic [11:0] C_BEQ  = 12'b0000001_00_001;
    localparam logic [11:0] C_ADDI = 12'b0110000_00_000;
    localparam logic [11:0] C_ANDI = 12'b0110000_00_011;
    localparam logic [11:0] C_ORI  = 12'b0110000_00_100;
    localparam logic [11:0] C_SLTI = 12'b0110000_00_101;

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic        e_stall;
        logic        e_valid;
        logic [11:0] e_ctrl;
        logic        chk;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
    } vec_t;

    localparam int NV = 24;
    vec_t tv [NV];

    function automatic vec_t mk(input logic vld, input logic [31:0] instr,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic fl, input logic e_stall, input logic e_valid,
                                input logic [11:0] e_ctrl, input logic chk,
                                input logic [31:0] e_rs, input logic [31:0] e_rt,
                                input logic [31:0] e_imm, input logic [4:0] e_rd);
        vec_t v;
        v.vld = vld; v.instr = instr; v.we = we; v.wa = wa; v.wd = wd; v.fl = fl;
        v.e_stall = e_stall; v.e_valid = e_valid; v.e_ctrl = e_ctrl; v.chk = chk;
        v.e_rs = e_rs; v.e_rt = e_rt; v.e_imm = e_imm; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] ctrl_now();
        return {ex_reg_dst, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read,
                ex_mem_to_reg, ex_branch, ex_load_mode, ex_alu_op};
    endfunction

    task automatic drive(input logic vld, input logic [31:0] instr, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if_valid = vld; if_instr = instr; flush = fl;
        wb_we = we; wb_waddr = wa; wb_wdata = wd;
    endtask

    initial begin
        //          vld instr         we wa     wd            fl st vl ctrl    chk rs_data       rt_data       imm           rd
        tv[0]  = mk(0, 32'h00000000, 1, 5'd1, 32'h00000005, 0, 0, 0, C_NONE, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tv[1]  = mk(1, 32'h00210820, 0, 5'd0, 32'h00000000, 0, 0, 1, C_R,    1, 32'h5, 32'h5, 32'h820, 5'd1);
        tv[2]  = mk(1, 32'h00421020, 1, 5'd2, 32'h00001234, 0, 0, 1, C_R,    1, 32'h1234, 32'h1234, 32'h1020, 5'd2);
        tv[3]  = mk(0, 32'h00000000, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, C_NONE, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tv[4]  = mk(1, 32'h00000820, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 1, C_R,    1, 32'h0, 32'h0, 32'h820, 5'd1);
        tv[5]  = mk(1, 32'h8C030004, 0, 5'd0, 32'h00000000, 0, 0, 1, C_LW,   1, 32'h0, 32'h0, 32'h4, 5'd0);
        tv[6]  = mk(1, 32'h00632020, 1, 5'd3, 32'h0000ABCD, 0, 1, 0, C_NONE, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tv[7]  = mk(1, 32'h00632020, 0, 5'd0, 32'h00000000, 0, 0, 1, C_R,    1, 32'hABCD, 32'hABCD, 32'h2020, 5'd4);
        tv[8]  = mk(1, 32'h8C030004, 0, 5'd0, 32'h00000000, 0, 0, 1, C_LW,   1, 32'h0, 32'hABCD, 32'h4, 5'd0);
        tv[9]  = mk(1, 32'h00632020, 0, 5'd0, 32'h00000000, 1, 0, 0, C_NONE, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tv[10] = mk(1, 32'hAC030008, 0, 5'd0, 32'h00000000, 0, 0, 1, C_SW,   1, 32'h0, 32'hABCD, 32'h8, 5'd0);
        tv[11] = mk(1, 32'h8405FFFC, 0, 5'd0, 32'h00000000, 0, 0, 1, C_LH,   1, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd31);
        tv[12] = mk(1, 32'h80060010, 0, 5'd0, 32'h00000000, 0, 0, 1, C_LB,   1, 32'h0, 32'h0, 32'h10, 5'd0);
        tv[13] = mk(1, 32'h10060003, 0, 5'd0, 32'h00000000, 0, 1, 0, C_NONE, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tv[14] = mk(1, 32'h10060003, 0, 5'd0, 32'h00000000, 0, 0, 1, C_BEQ,  1, 32'h0, 32'h0, 32'h3, 5'd0);
        tv[15] = mk(1, 32'h8C070000, 0, 5'd0, 32'h00000000, 0, 0, 1, C_LW,   1, 32'h0, 32'h0, 32'h0, 5'd0);
        tv[16] = mk(1, 32'h20070001, 0, 5'd0, 32'h00000000, 0, 0, 1, C_ADDI, 1, 32'h0, 32'h0, 32'h1, 5'd0);
        tv[17] = mk(1, 32'h8C000000, 0, 5'd0, 32'h00000000, 0, 0, 1, C_LW,   1, 32'h0, 32'h0, 32'h0, 5'd0);
        tv[18] = mk(1, 32'h00000820, 0, 5'd0, 32'h00000000, 0, 0, 1, C_R,    1, 32'h0, 32'h0, 32'h820, 5'd1);
        tv[19] = mk(1, 32'h3001FFFF, 0, 5'd0, 32'h00000000, 0, 0, 1, C_ANDI, 1, 32'h0, 32'h5, 32'hFFFFFFFF, 5'd31);
        tv[20] = mk(1, 32'h34010001, 0, 5'd0, 32'h00000000, 0, 0, 1, C_ORI,  1, 32'h0, 32'h5, 32'h1, 5'd0);
        tv[21] = mk(1, 32'h28018000, 0, 5'd0, 32'h00000000, 0, 0, 1, C_SLTI, 1, 32'h0, 32'h5, 32'hFFFF8000, 5'd16);
        tv[22] = mk(1, 32'h08000000, 0, 5'd0, 32'h00000000, 0, 0, 1, C_NONE, 1, 32'h0, 32'h0, 32'h0, 5'd0);
        tv[23] = mk(0, 32'h00000000, 0, 5'd0, 32'h00000000, 0, 0, 0, C_NONE, 0, 32'h0, 32'h0, 32'h0, 5'd0);

        reset = 1'b1;
        if_pc_plus4 = 32'h0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset ctrl", {20'd0, ctrl_now()}, 32'd0);
        chk("reset rs_data", ex_rs_data, 32'd0);
        chk("reset pc", ex_pc_plus4, 32'd0);
`ifdef ID_PERF_CNT_EN
        chk("reset stall_count", stall_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].vld, tv[i].instr, tv[i].fl, tv[i].we, tv[i].wa, tv[i].wd);
            if_pc_plus4 = 32'h1000 + 32'(4 * i);
            #1;
            chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, tv[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, tv[i].e_valid});
            chk($sformatf("v%0d ctrl", i), {20'd0, ctrl_now()}, {20'd0, tv[i].e_ctrl});
            if (tv[i].chk) begin
                chk($sformatf("v%0d rs_data", i), ex_rs_data, tv[i].e_rs);
                chk($sformatf("v%0d rt_data", i), ex_rt_data, tv[i].e_rt);
                chk($sformatf("v%0d imm", i), ex_imm, tv[i].e_imm);
                chk($sformatf("v%0d rd", i), {27'd0, ex_rd}, {27'd0, tv[i].e_rd});
                chk($sformatf("v%0d pc", i), ex_pc_plus4, 32'h1000 + 32'(4 * i));
            end
        end
`ifdef ID_PERF_CNT_EN
        chk("stall_count", stall_count, 32'd2);
        chk("flush_count", flush_count, 32'd1);
`endif

        // Reset arriving while a load-use stall is pending.
        @(negedge clk);
        drive(1'b1, 32'h8C030004, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 32'h00632020, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("mid-stall stall before reset", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid-stall stall after reset", {31'd0, stall}, 32'd0);
        chk("mid-stall ex_valid after reset", {31'd0, ex_valid}, 32'd0);
        chk("mid-stall ctrl after reset", {20'd0, ctrl_now()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h00210820, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("post-reset r1 cleared", ex_rs_data, 32'd0);
        chk("post-reset ex_valid", {31'd0, ex_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised MIPS decode stage with its own ID/EX pipeline register. Next generation of the fixed-width 32-bit decode stage.
- Holds a NUM_REGS x XLEN register file with WB write-through bypass, decodes the main opcode set, and sign-extends the immediate.
- Detects load-use hazards and drives a stall to IF, and accepts a branch flush from EX.
- Sits between IF/ID and EX; WB write-back feeds back into it.

Parameters:
- XLEN, 32, register/data width; immediate sign-extended to XLEN.
- NUM_REGS, 32, register count, power of 2 in 2..32. RA_W = clog2(NUM_REGS) is derived, not overridable.
- PC_W, 32, width of the PC+4 value carried through.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_valid  in  1  if_instr holds a real instruction
- if_instr  in  32  instruction from IF/ID
- if_pc_plus4  in  PC_W  PC+4 from IF/ID
- flush  in  1  branch taken in EX; kill the instruction in ID
- wb_we  in  1  write-back enable
- wb_waddr  in  RA_W  write-back register
- wb_wdata  in  XLEN  write-back data
- stall  out  1  combinational; IF must hold PC and IF/ID
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc_plus4  out  PC_W  registered PC+4
- ex_rs_data, ex_rt_data  out  XLEN  registered operands
- ex_imm  out  XLEN  sign-extended instr[15:0]
- ex_rs, ex_rt, ex_rd  out  RA_W  register fields, low RA_W bits of each 5-bit field
- ex_reg_dst, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch  out  1 each  control bits
- ex_load_mode  out  2  00 word, 01 half, 10 byte
- ex_alu_op  out  3  000 add, 001 sub, 010 R-type/funct, 011 and, 100 or, 101 slt

Behaviour:
- Reset (async): every register-file entry, every ex_* output and ex_valid go to 0.
- Register 0 always reads 0. Writes to register 0 are ignored.
- Register-file writes occur on the rising edge when wb_we=1.
- Read bypass: if wb_we is high and wb_waddr equals a nonzero read address, the read returns wb_wdata in the same cycle.
- Decode, with latency 1 cycle (ID/EX updates on the rising edge):
  - R-type 000000: reg_dst, reg_write, alu_op=010.
  - lw 100011, lh 100001, lb 100000: alu_src, mem_read, mem_to_reg, reg_write, alu_op=000; load_mode 00/01/10 respectively.
  - sw 101011: alu_src, mem_write, alu_op=000.
  - beq 000100: branch, alu_op=001.
  - addi 001000: alu_src, reg_write, alu_op=000.
  - andi 001100: alu_src, reg_write, alu_op=011.
  - ori 001101: alu_src, reg_write, alu_op=100.
  - slti 001010: alu_src, reg_write, alu_op=101.
  - Any other opcode: all control bits 0, with ex_valid still following if_valid.
- Hazard: stall = if_valid & ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == rs, or ex_rt == rt when the instruction reads rt, i.e. R-type/sw/beq) & ~flush.
- Next-state priority for ID/EX:
  1. flush: insert a bubble.
  2. stall: insert a bubble.
  3. if_valid=0: insert a bubble.
  4. Otherwise load the decoded instruction.
- Bubble definition: ex_valid=0 and all control bits 0. Data fields may hold don't-care values; the bench checks only ex_valid and control.
- A stall lasts exactly one cycle per load-use pair, because the bubble clears ex_mem_read.
- Reset asserted mid-stall clears ex_valid, so stall deasserts immediately.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- When defined, adds output ports stall_count[31:0] and flush_count[31:0]:
  - stall_count increments every cycle stall=1.
  - flush_count increments every cycle flush=1 && if_valid=1.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and their registers do not exist, and all other behaviour is unchanged.

Decomposition:
- Package mips_pkg holds: opcode constants, ALU_OP_* constants, LOAD_* constants, and the control-bundle struct (reg_dst … alu_op).
- One sub-module, id_regfile: parametrised on XLEN and NUM_REGS, with 2 read ports, 1 write port, zero register and bypass.
- Decode logic and the hazard unit stay in id_stage_pipe.

Test Plan:
- Write register 1: reset, then wb writes r1=5. Decode 0x00210820 (add r1,r1,r1) -> next cycle ex_rs_data=ex_rt_data=5, ex_rd=1, reg_dst=1, reg_write=1, alu_op=010, ex_valid=1.
- Same-cycle bypass: wb writes r2=0x1234 in the same cycle as decode of 0x00421020 -> ex_rs_data=ex_rt_data=0x1234.
- Register 0 protection: wb_we to r0 with 0xFFFFFFFF, then decode 0x00000820 -> ex_rs_data=0.
- Load-use: decode 0x8C030004 (lw r3,4(r0)), then hold 0x00632020 (add r4,r3,r3) -> stall=1 for exactly one cycle, a bubble in ID/EX, then the add issues with ex_valid=1. With ID_PERF_CNT_EN, stall_count=1.
- Flush priority: flush=1 during that load-use stall cycle -> stall=0 and ex_valid=0 next cycle.
- Signed load: decode 0x8405FFFC (lh r5,-4(r0)) -> ex_imm=0xFFFFFFFC, load_mode=01, mem_read=1, alu_src=1, mem_to_reg=1. XLEN=64 build gives ex_imm=0xFFFFFFFFFFFFFFFC.
